// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with optional external sync lock (VGA_EXT_LOCK_EN)
// Column/row counters with boundary-stepped region FSMs; every output is registered from the next-state counters.
module vga_timing_gen #(
    parameter int   H_VISIBLE = 800,
    parameter int   H_FRONT   = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BACK    = 88,
    parameter int   V_VISIBLE = 600,
    parameter int   V_FRONT   = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BACK    = 23,
    parameter logic H_POL     = 1'b1,
    parameter logic V_POL     = 1'b1,
    parameter int   COL_W     = 12,
    parameter int   ROW_W     = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
`ifdef VGA_EXT_LOCK_EN
    input  logic             ext_hsync,
    input  logic             ext_vsync,
    output logic             locked,
`endif
    output logic [COL_W-1:0] display_col,
    output logic [ROW_W-1:0] display_row,
    output logic             visible,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COL_W-1:0] H_LAST        = COL_W'(H_TOTAL - 1);
    localparam logic [COL_W-1:0] H_FRONT_START = COL_W'(H_VISIBLE);
    localparam logic [COL_W-1:0] H_SYNC_START  = COL_W'(H_VISIBLE + H_FRONT);
    localparam logic [COL_W-1:0] H_BACK_START  = COL_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [ROW_W-1:0] V_LAST        = ROW_W'(V_TOTAL - 1);
    localparam logic [ROW_W-1:0] V_FRONT_START = ROW_W'(V_VISIBLE);
    localparam logic [ROW_W-1:0] V_SYNC_START  = ROW_W'(V_VISIBLE + V_FRONT);
    localparam logic [ROW_W-1:0] V_BACK_START  = ROW_W'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} region_e;

    region_e          h_state_q, v_state_q;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d, row_inc;
    logic             visible_q, hsync_q, vsync_q, line_start_q, frame_start_q;
    logic             hs_apply, vs_apply;

`ifdef VGA_EXT_LOCK_EN
    // [0],[1] form the synchroniser, [2] is the previous synchronised level for edge detection.
    logic [2:0] hs_sync_q, vs_sync_q;
    logic       hs_pend_q, vs_pend_q, locked_q;
    logic       hs_req, vs_req;

    assign hs_req   = hs_pend_q | ((hs_sync_q[1] == H_POL) && (hs_sync_q[2] != H_POL));
    assign vs_req   = vs_pend_q | ((vs_sync_q[1] == V_POL) && (vs_sync_q[2] != V_POL));
    assign vs_apply = enable & vs_req;
    assign hs_apply = enable & hs_req & ~vs_req;
    assign locked   = locked_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hs_sync_q <= {3{~H_POL}};
            vs_sync_q <= {3{~V_POL}};
            hs_pend_q <= 1'b0;
            vs_pend_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            hs_sync_q <= {hs_sync_q[1:0], ext_hsync};
            vs_sync_q <= {vs_sync_q[1:0], ext_vsync};
            if (enable) begin
                hs_pend_q <= 1'b0;
                vs_pend_q <= 1'b0;
            end else begin
                hs_pend_q <= hs_req;
                vs_pend_q <= vs_req;
            end
            // Lock means the external line edge lands exactly where the free-running line would wrap.
            if (vs_apply) begin
                if (col_q != H_LAST) locked_q <= 1'b0;
            end else if (hs_apply) begin
                locked_q <= (col_q == H_LAST);
            end
        end
    end
`else
    assign hs_apply = 1'b0;
    assign vs_apply = 1'b0;
`endif

    assign row_inc = (row_q == V_LAST) ? '0 : row_q + 1'b1;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (enable) begin
            if (vs_apply) begin
                col_d = '0;
                row_d = '0;
            end else if (hs_apply || (col_q == H_LAST)) begin
                col_d = '0;
                row_d = row_inc;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q         <= H_LAST;
            row_q         <= V_LAST;
            visible_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            line_start_q  <= enable && (col_d == '0);
            frame_start_q <= enable && (col_d == '0) && (row_d == '0);
            if (enable) begin
                visible_q <= (col_d < H_FRONT_START) && (row_d < V_FRONT_START);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_state_q <= ST_BACK;
            hsync_q   <= ~H_POL;
        end else if (enable) begin
            if (col_d == '0) begin
                h_state_q <= ST_ACTIVE;
                hsync_q   <= ~H_POL;
            end else begin
                case (h_state_q)
                    ST_ACTIVE: if (col_d == H_FRONT_START) begin
                        h_state_q <= ST_FRONT;
                        hsync_q   <= ~H_POL;
                    end
                    ST_FRONT: if (col_d == H_SYNC_START) begin
                        h_state_q <= ST_SYNC;
                        hsync_q   <= H_POL;
                    end
                    ST_SYNC: if (col_d == H_BACK_START) begin
                        h_state_q <= ST_BACK;
                        hsync_q   <= ~H_POL;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The vertical machine only moves when a new line begins, so vsync spans whole rows.
    always_ff @(posedge clock) begin
        if (reset) begin
            v_state_q <= ST_BACK;
            vsync_q   <= ~V_POL;
        end else if (enable && (col_d == '0)) begin
            if (row_d == '0) begin
                v_state_q <= ST_ACTIVE;
                vsync_q   <= ~V_POL;
            end else begin
                case (v_state_q)
                    ST_ACTIVE: if (row_d == V_FRONT_START) begin
                        v_state_q <= ST_FRONT;
                        vsync_q   <= ~V_POL;
                    end
                    ST_FRONT: if (row_d == V_SYNC_START) begin
                        v_state_q <= ST_SYNC;
                        vsync_q   <= V_POL;
                    end
                    ST_SYNC: if (row_d == V_BACK_START) begin
                        v_state_q <= ST_BACK;
                        vsync_q   <= ~V_POL;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign display_col = col_q;
    assign display_row = row_q;
    assign visible     = visible_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen: pixel-index model, default and small-raster instances
module tb_vga_timing_gen;

    localparam int H0 = 1056, T0 = 1056 * 628;
    localparam int H1 = 24,   T1 = 24 * 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    always #5 clock = ~clock;

    logic [11:0] col0;
    logic [10:0] row0;
    logic        vis0, hs0, vs0, ls0, fs0;
    logic [4:0]  col1;
    logic [3:0]  row1;
    logic        vis1, hs1, vs1, ls1, fs1;
`ifdef VGA_EXT_LOCK_EN
    logic ext_hs0 = 1'b0, ext_vs0 = 1'b0;
    logic lk0, lk1;
`endif

    vga_timing_gen dut0 (
        .clock(clock), .reset(reset), .enable(enable),
`ifdef VGA_EXT_LOCK_EN
        .ext_hsync(ext_hs0), .ext_vsync(ext_vs0), .locked(lk0),
`endif
        .display_col(col0), .display_row(row0), .visible(vis0), .hsync(hs0),
        .vsync(vs0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .H_POL(1'b0), .V_POL(1'b1), .COL_W(5), .ROW_W(4)
    ) dut1 (
        .clock(clock), .reset(reset), .enable(enable),
`ifdef VGA_EXT_LOCK_EN
        .ext_hsync(1'b1), .ext_vsync(1'b0), .locked(lk1),
`endif
        .display_col(col1), .display_row(row1), .visible(vis1), .hsync(hs1),
        .vsync(vs1), .line_start(ls1), .frame_start(fs1)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 0;
    bit chk0     = 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected {visible, hsync, vsync} for a raster position.
    function automatic logic [2:0] flags(input int col, input int row, input int hv, input int hf,
                                         input int hs, input int vv, input int vf, input int vs,
                                         input logic hp, input logic vp);
        logic v, h, w;
        v = (col < hv) && (row < vv);
        h = (col >= hv + hf && col < hv + hf + hs) ? hp : ~hp;
        w = (row >= vv + vf && row < vv + vf + vs) ? vp : ~vp;
        return {v, h, w};
    endfunction

    // Model: a linear pixel index within the frame; reset parks it on the last pixel.
    int m0, m1;
    bit mls0, mfs0, mls1, mfs1;
    always @(posedge clock) begin : model
        int n0, n1;
        n0 = (m0 + 1) % T0;
        n1 = (m1 + 1) % T1;
        if (reset) begin
            m0 <= T0 - 1; m1 <= T1 - 1;
            mls0 <= 0; mfs0 <= 0; mls1 <= 0; mfs1 <= 0;
        end else if (enable) begin
            m0 <= n0; m1 <= n1;
            mls0 <= (n0 % H0 == 0); mfs0 <= (n0 == 0);
            mls1 <= (n1 % H1 == 0); mfs1 <= (n1 == 0);
        end else begin
            mls0 <= 0; mfs0 <= 0; mls1 <= 0; mfs1 <= 0;
        end
    end

    always @(negedge clock) begin : cmp
        logic [2:0] f0, f1;
        if (chk_on) begin
            if (chk0) begin
                f0 = flags(m0 % H0, m0 / H0, 800, 40, 128, 600, 1, 4, 1'b1, 1'b1);
                check("d0_col", int'(col0), m0 % H0);
                check("d0_row", int'(row0), m0 / H0);
                check("d0_visible", int'(vis0), int'(f0[2]));
                check("d0_hsync", int'(hs0), int'(f0[1]));
                check("d0_vsync", int'(vs0), int'(f0[0]));
                check("d0_line_start", int'(ls0), int'(mls0));
                check("d0_frame_start", int'(fs0), int'(mfs0));
`ifdef VGA_EXT_LOCK_EN
                check("d0_locked", int'(lk0), 0);
`endif
            end
            f1 = flags(m1 % H1, m1 / H1, 16, 2, 3, 10, 1, 2, 1'b0, 1'b1);
            check("d1_col", int'(col1), m1 % H1);
            check("d1_row", int'(row1), m1 / H1);
            check("d1_visible", int'(vis1), int'(f1[2]));
            check("d1_hsync", int'(hs1), int'(f1[1]));
            check("d1_vsync", int'(vs1), int'(f1[0]));
            check("d1_line_start", int'(ls1), int'(mls1));
            check("d1_frame_start", int'(fs1), int'(mfs1));
`ifdef VGA_EXT_LOCK_EN
            check("d1_locked", int'(lk1), 0);
`endif
        end
    end

    task automatic tick(input logic en);
        enable = en;
        @(posedge clock);
        #1;
    endtask

    task automatic step0(input int c);
        int n = 0;
        while (int'(col0) != c && n < 2200) begin tick(1'b1); n++; end
        check("reach_col0", int'(col0), c);
    endtask

    task automatic step1(input int r, input int c);
        int n = 0;
        while (!(int'(row1) == r && int'(col1) == c) && n < 500) begin tick(1'b1); n++; end
        check("reach_row1", int'(row1), r);
        check("reach_col1", int'(col1), c);
    endtask

    initial begin
        tick(1'b0);
        chk_on = 1;
        tick(1'b1);
        check("rst_col", int'(col0), 1055);
        check("rst_row", int'(row0), 627);
        check("rst_vis", int'(vis0), 0);
        check("rst_hs", int'(hs0), 0);
        check("rst_ls", int'(ls0), 0);
        check("rst_fs", int'(fs0), 0);
        check("rst_col1", int'(col1), 23);
        check("rst_row1", int'(row1), 15);
        check("rst_hs1", int'(hs1), 1);
        reset = 0;
        tick(1'b1);
        check("first_col", int'(col0), 0);
        check("first_row", int'(row0), 0);
        check("first_vis", int'(vis0), 1);
        check("first_ls", int'(ls0), 1);
        check("first_fs", int'(fs0), 1);
        for (int i = 0; i < 1055; i++) tick(1'b1);
        check("line_end_col", int'(col0), 1055);
        tick(1'b1);
        check("wrap_col", int'(col0), 0);
        check("wrap_row", int'(row0), 1);
        check("wrap_ls", int'(ls0), 1);
        check("wrap_fs", int'(fs0), 0);

        step0(799);  check("vis_799", int'(vis0), 1);
        tick(1'b1);  check("vis_800", int'(vis0), 0);
        step0(839);  check("hs_839", int'(hs0), 0);
        tick(1'b1);  check("hs_840", int'(hs0), 1);
        step0(967);  check("hs_967", int'(hs0), 1);
        tick(1'b1);  check("hs_968", int'(hs0), 0);

        step0(1055);
        tick(1'b1); check("en1_col", int'(col0), 0); check("en1_ls", int'(ls0), 1);
        tick(1'b0); check("en0a_col", int'(col0), 0); check("en0a_ls", int'(ls0), 0);
        tick(1'b0); check("en0b_col", int'(col0), 0); check("en0b_ls", int'(ls0), 0);
        tick(1'b1); check("en1b_col", int'(col0), 1); check("en1b_ls", int'(ls0), 0);

        step0(500);
        reset = 1;
        tick(1'b1);
        check("mid_rst_col", int'(col0), 1055);
        check("mid_rst_row", int'(row0), 627);
        check("mid_rst_vis", int'(vis0), 0);
        reset = 0;
        tick(1'b0);
        tick(1'b1);
        check("post_rst_fs", int'(fs0), 1);
        check("post_rst_col", int'(col0), 0);

        reset = 1; tick(1'b0); reset = 0;
        step1(10, 23); check("vs1_row10", int'(vs1), 0);
        tick(1'b1);
        check("vs1_row11", int'(vs1), 1);
        check("vis1_row11", int'(vis1), 0);
        check("ls1_row11", int'(ls1), 1);
        step1(12, 23); check("vs1_row12", int'(vs1), 1);
        tick(1'b1);    check("vs1_row13", int'(vs1), 0);
        step1(15, 23);
        tick(1'b1);
        check("wrap1_row", int'(row1), 0);
        check("wrap1_fs", int'(fs1), 1);
        check("wrap1_vis", int'(vis1), 1);

        for (int i = 0; i < 6000; i++) begin
            reset = ($urandom_range(0, 1999) == 0);
            tick($urandom_range(0, 3) != 0);
        end
        reset = 0;
        tick(1'b1);

`ifdef VGA_EXT_LOCK_EN
        begin
            int rb;
            chk0 = 0;
            reset = 1; tick(1'b0); reset = 0;
            step0(700);
            rb = int'(row0);
            ext_hs0 = 1'b1;
            for (int i = 1; i <= 3; i++) tick(1'b1);
            check("ext_col", int'(col0), 0);
            check("ext_row", int'(row0), rb + 1);
            check("ext_locked0", int'(lk0), 0);
            check("ext_ls", int'(ls0), 1);
            for (int i = 4; i <= 1056; i++) begin
                if (i == 10) ext_hs0 = 1'b0;
                tick(1'b1);
            end
            ext_hs0 = 1'b1;
            for (int i = 0; i < 3; i++) tick(1'b1);
            check("ext_locked1", int'(lk0), 1);
            check("ext_col2", int'(col0), 0);
            for (int i = 0; i < 10; i++) begin
                if (i == 1) ext_hs0 = 1'b0;
                tick(1'b1);
            end
            ext_hs0 = 1'b1;
            ext_vs0 = 1'b1;
            for (int i = 0; i < 3; i++) tick(1'b1);
            check("ext_both_col", int'(col0), 0);
            check("ext_both_row", int'(row0), 0);
            check("ext_both_fs", int'(fs0), 1);
        end
`endif

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_VISIBLE, 800, active columns.
- H_FRONT, 40, horizontal front porch in pixels.
- H_SYNC, 128, hsync pulse width in pixels.
- H_BACK, 88, horizontal back porch in pixels.
- V_VISIBLE, 600, active rows.
- V_FRONT, 1, vertical front porch in lines.
- V_SYNC, 4, vsync pulse width in lines.
- V_BACK, 23, vertical back porch in lines.
- H_POL, 1, hsync active level.
- V_POL, 1, vsync active level.
- COL_W, 12, column counter width.
- ROW_W, 11, row counter width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, single clock.
- reset, in, 1, reset; synchronous, active-high.
- enable, in, 1, pixel strobe; state advances only on edges where enable=1.
- display_col, out, COL_W, current column.
- display_row, out, ROW_W, current row.
- visible, out, 1, current pixel lies in the active area.
- hsync, out, 1, horizontal sync at H_POL level when active.
- vsync, out, 1, vertical sync at V_POL level when active.
- line_start, out, 1, one-strobe pulse at column 0.
- frame_start, out, 1, one-strobe pulse at column 0, row 0.
REQ-003 Derived totals SHALL be H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK; the parameter set is legal only if H_TOTAL <= 2^COL_W and V_TOTAL <= 2^ROW_W.

Function
REQ-004 Column order SHALL be: active 0..H_VISIBLE-1, then front porch, then sync, then back porch, ending at H_TOTAL-1. Rows SHALL follow the same order.
REQ-005 A horizontal state machine H_ACTIVE->H_FRONT->H_SYNC->H_BACK->H_ACTIVE SHALL change state on the enabled edge at which the column reaches each region boundary. The vertical state machine SHALL use the same state set, stepping only on column wrap.
REQ-006 On each enabled edge the column SHALL increment, wrapping from H_TOTAL-1 to 0. On that wrap the row SHALL increment, wrapping from V_TOTAL-1 to 0.
REQ-007 All outputs SHALL be registered and decoded from the updated counter values at the same edge, so every output describes the same pixel with zero relative skew.
REQ-008 visible SHALL equal (display_col < H_VISIBLE) AND (display_row < V_VISIBLE).
REQ-009 hsync SHALL be at the H_POL level iff display_col lies in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]. vsync SHALL be at the V_POL level iff display_row lies in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], for the whole row.
REQ-010 line_start and frame_start SHALL be high for exactly one enabled strobe. They SHALL be forced low on any edge where enable=0.
REQ-011 With enable=0, the counters, visible, hsync and vsync SHALL hold their values.

Reset
REQ-012 While reset=1 the outputs SHALL be: display_col=H_TOTAL-1, display_row=V_TOTAL-1, visible=0, hsync=~H_POL, vsync=~V_POL, line_start=0, frame_start=0; all FSMs SHALL be in their BACK state.
REQ-013 The first enabled edge after reset SHALL give col=0, row=0, visible=1, line_start=1, frame_start=1.
REQ-014 Reset asserted mid-frame SHALL take effect on the next clock edge, with priority over enable and over external lock.

Configuration
REQ-015 Macro VGA_EXT_LOCK_EN SHALL control external lock. When it is undefined, the block SHALL be free-running, with none of the ports below.
REQ-016 When VGA_EXT_LOCK_EN is defined, the block SHALL add inputs ext_hsync and ext_vsync and output locked.
- Each input SHALL pass through a 2-flop synchroniser and then active-edge detection, using the H_POL/V_POL sense.
- An ext_vsync edge SHALL force col=0, row=0 and frame_start=1 on the next enabled edge.
- Otherwise, an ext_hsync edge SHALL force col=0, advance the row with wrap, and give line_start=1.
- If both edges are pending, ext_vsync SHALL win.
- Edges seen while enable=0 SHALL stay pending until the next enabled edge.
- locked SHALL set when an ext_hsync edge is applied while col=H_TOTAL-1. It SHALL clear when an edge is applied at any other column. Reset value of locked is 0.

Verification
REQ-017 Reset, then 1056 enabled strobes -> col 0..1055 then 0. line_start SHALL be high at strobe 1 and strobe 1057.
REQ-018 Free run, defaults -> hsync high exactly at cols 840..967; vsync high exactly at rows 601..604; visible low at col 800 and at row 600.
REQ-019 enable toggling 1,0,0,1 -> the counter advances twice, and the pulses never stay high during enable=0.
REQ-020 Assert reset at col 500, row 300 -> the next edge gives col 1055, row 627, visible 0; the first enabled edge after release gives frame_start=1 at (0,0).
REQ-021 With VGA_EXT_LOCK_EN, inject an ext_hsync edge at col 700 -> col=0 a fixed 3 enabled edges after the edge, row+1, locked=0. Repeat the edge at a 1056-pixel period -> locked=1.
REQ-022 With VGA_EXT_LOCK_EN, give ext_hsync and ext_vsync edges on the same cycle -> col=0, row=0, frame_start=1.
